mem_access_stage: RTL

- Memory stage of the 5-stage pipeline.
- Consumes the execute-to-memory bundle, performs loads and stores over a req/gnt/rvalid data-memory port, and registers the memory-to-writeback bundle.
- Stalls upstream while a data access is outstanding.

---
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory stage: turns the execute bundle into a req/gnt/rvalid data access and
// registers the writeback bundle, stalling upstream while an access is in flight.
module mem_access_stage #(
    parameter int REG_WIDTH = 32,
    parameter int REG_COUNT = 32,
    parameter int CTRL_SIZE = 21,
    parameter int REG_BITS  = $clog2(REG_COUNT)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [REG_BITS+1+CTRL_SIZE-7+3*REG_WIDTH+1-1:0] exc_mem_reg,
    input  logic                                            in_valid,
    output logic                                            stall,
    output logic                                            dmem_req,
    output logic                                            dmem_we,
    output logic [31:0]                                     dmem_addr,
    output logic [3:0]                                      dmem_be,
    output logic [31:0]                                     dmem_wdata,
    input  logic                                            dmem_gnt,
    input  logic                                            dmem_rvalid,
    input  logic [31:0]                                     dmem_rdata,
    output logic [REG_BITS+REG_WIDTH:0]                     mem_wb_reg,
    output logic                                            mem_wb_valid,
    output logic                                            misaligned
);

    localparam int MCTRL_W = CTRL_SIZE - 7;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    logic [REG_BITS-1:0]  rd;
    logic                 write_en;
    logic [MCTRL_W-1:0]   mctrl;
    logic [REG_WIDTH-1:0] alu_out;
    logic                 alu_zero;
    logic [REG_WIDTH-1:0] store_data;
    logic [REG_WIDTH-1:0] return_pc;

    assign {rd, write_en, mctrl, alu_out, alu_zero, store_data, return_pc} = exc_mem_reg;

    logic       mem_read, mem_write, load_uns, mem_op, misal_op;
    logic [1:0] size, wb_sel, off;

    assign mem_read  = mctrl[13];
    assign mem_write = mctrl[12];
    assign size      = mctrl[11:10];
    assign load_uns  = mctrl[9];
    assign wb_sel    = mctrl[8:7];
    assign off       = alu_out[1:0];
    assign mem_op    = mem_read | mem_write;
    assign misal_op  = mem_op & (((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00)));

    logic unused_fields;
    assign unused_fields = &{1'b0, alu_zero, mctrl[6:0]};

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] o);
        case (sz)
            2'b00:   lane_be = 4'b0001 << o;
            2'b01:   lane_be = 4'b0011 << o;
            default: lane_be = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic uns,
                                                 input logic [1:0] o, input logic [31:0] rdat);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdat[8*o +: 8];
        h = rdat[16*o[1] +: 16];
        case (sz)
            2'b00:   load_extract = {{24{b[7] & ~uns}}, b};
            2'b01:   load_extract = {{16{h[15] & ~uns}}, h};
            default: load_extract = rdat;
        endcase
    endfunction

    // Request-side fields follow exc_mem_reg directly; upstream holds it stable while stalled.
    assign dmem_we    = mem_write;
    assign dmem_addr  = {alu_out[31:2], 2'b00};
    assign dmem_be    = lane_be(size, off);
    assign dmem_wdata = lane_data(size, store_data);

    state_t                      state_q, state_d;
    logic [REG_BITS+REG_WIDTH:0] mem_wb_reg_q, mem_wb_reg_d;
    logic                        mem_wb_valid_q, mem_wb_valid_d;
    logic                        misaligned_q, misaligned_d;
    logic                        issue, req_c, stall_c, retire_c;
    logic [REG_WIDTH-1:0]        wb_data;

    always_comb begin
        case (wb_sel)
            2'b01:   wb_data = load_extract(size, load_uns, off, dmem_rdata);
            2'b10:   wb_data = return_pc;
            default: wb_data = alu_out;
        endcase
    end

    assign issue = (state_q == S_REQ) ||
                   ((state_q == S_IDLE) && in_valid && mem_op && !misal_op);

    always_comb begin
        state_d        = state_q;
        mem_wb_reg_d   = mem_wb_reg_q;
        mem_wb_valid_d = 1'b0;
        misaligned_d   = 1'b0;
        req_c          = 1'b0;
        stall_c        = 1'b0;
        retire_c       = 1'b0;
        if (issue) begin
            req_c = 1'b1;
            if (!dmem_gnt) begin
                state_d = S_REQ;
                stall_c = 1'b1;
            end else if (mem_write) begin
                state_d  = S_IDLE;
                retire_c = 1'b1;
            end else begin
                state_d = S_WAIT;
                stall_c = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE:  retire_c = in_valid;
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        state_d  = S_IDLE;
                        retire_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (retire_c) begin
            mem_wb_reg_d   = {rd, write_en & ~misal_op, wb_data};
            mem_wb_valid_d = 1'b1;
            misaligned_d   = misal_op;
        end
    end

    // Reset forces the handshake outputs low without waiting for a clock edge.
    assign dmem_req = req_c & ~rst;
    assign stall    = stall_c & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mem_wb_reg_q   <= '0;
            mem_wb_valid_q <= 1'b0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_wb_reg_q   <= mem_wb_reg_d;
            mem_wb_valid_q <= mem_wb_valid_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign mem_wb_reg   = mem_wb_reg_q;
    assign mem_wb_valid = mem_wb_valid_q;
    assign misaligned   = misaligned_q;

endmodule
